// File: rtl/shreg_seq_ctrl.sv
// Sequencing controller for a ring/Johnson shift register: loads a seed, then
// shifts for a captured number of steps with hold/abort, reporting busy/done/wrap.
module shreg_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] seed_r;
  logic             mode_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_next;

  // Ring rotates the MSB back into bit 0; Johnson feeds back its complement.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic            johnson);
    logic fb;
    fb = johnson ? ~v[WIDTH-1] : v[WIDTH-1];
    return {v[WIDTH-2:0], fb};
  endfunction

  assign q_next = shift_step(q, mode_r);
  assign qb     = ~q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= '0;
      seed_r <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q      <= seed;
            seed_r <= seed;
            mode_r <= mode;
            cnt    <= steps;
            busy   <= 1'b1;
            if (steps != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins over hold and leaves q at its current value.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!hold) begin
            q    <= q_next;
            wrap <= (q_next == seed_r);
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end
            if (cnt <= CNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
